// File: rtl/dice_game_pkg.sv
// Shared types and width helper for the dice game engine.
package dice_game_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROLL   = 2'd1,
        CHOOSE = 2'd2,
        DONE   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        ADD  = 2'd1,
        SKIP = 2'd2,
        BUST = 2'd3
    } result_e;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dice_roller.sv
// Free-running 1..DIE_FACES roll counter with a latched, clearable roll value.
module dice_roller
    import dice_game_pkg::*;
#(
    parameter  int DIE_FACES = 6,
    localparam int DIE_W     = $clog2(DIE_FACES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             latch,
    input  logic             clr,
    output logic [DIE_W-1:0] value
);

    logic [DIE_W-1:0] roll_ctr_q, roll_ctr_d;
    logic [DIE_W-1:0] value_q, value_d;

    // Next counter value and latch/clear of the held roll.
    always_comb begin
        roll_ctr_d = roll_ctr_q + DIE_W'(1);
        value_d    = value_q;
        if (roll_ctr_q == DIE_W'(DIE_FACES)) begin
            roll_ctr_d = DIE_W'(1);
        end else begin
            roll_ctr_d = roll_ctr_q + DIE_W'(1);
        end
        if (latch) begin
            value_d = roll_ctr_q;
        end else if (clr) begin
            value_d = '0;
        end else begin
            value_d = value_q;
        end
    end

    // Counter and roll registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            roll_ctr_q <= DIE_W'(1);
            value_q    <= '0;
        end else begin
            roll_ctr_q <= roll_ctr_d;
            value_q    <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/dice_game_core.sv
// N-player dice game engine: roll/choose/score loop, turn budget, exact-target win.
// Optional macro DICE_BUST_RESET_EN: a bust zeroes the current player's score.
module dice_game_core
    import dice_game_pkg::*;
#(
    parameter  int NUM_PLAYERS = 2,
    parameter  int DIE_FACES   = 6,
    parameter  int TARGET      = 15,
    parameter  int MAX_TURNS   = 9,
    localparam int PID_W       = clog2_min1(NUM_PLAYERS),
    localparam int DIE_W       = $clog2(DIE_FACES + 1),
    localparam int SCORE_W     = $clog2(TARGET + 1),
    localparam int TURN_W      = $clog2(MAX_TURNS + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           btn,
    input  logic                           choice,
    output logic [1:0]                     state,
    output logic [PID_W-1:0]               player,
    output logic [DIE_W-1:0]               roll_value,
    output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
    output logic [TURN_W-1:0]              turns_left,
    output logic [1:0]                     last_result,
    output logic                           won,
    output logic                           draw,
    output logic [PID_W-1:0]               winner
);

    state_e                         state_q, state_d;
    result_e                        last_result_q, last_result_d;
    logic [PID_W-1:0]               player_q, player_d;
    logic [NUM_PLAYERS*SCORE_W-1:0] scores_q, scores_d;
    logic [TURN_W-1:0]              turns_left_q, turns_left_d;
    logic                           won_q, won_d;
    logic                           draw_q, draw_d;
    logic [PID_W-1:0]               winner_q, winner_d;
    logic                           btn_q;

    logic                           press_s;
    logic                           roll_latch_s;
    logic                           roll_clr_s;
    logic [SCORE_W-1:0]             cur_score_s;
    logic [SCORE_W:0]               sum_s;
    logic                           won_now_s;

    dice_roller #(
        .DIE_FACES (DIE_FACES)
    ) u_roller (
        .clk   (clk),
        .rst   (rst),
        .latch (roll_latch_s),
        .clr   (roll_clr_s),
        .value (roll_value)
    );

    assign press_s     = btn & ~btn_q;
    assign cur_score_s = scores_q[int'(player_q)*SCORE_W +: SCORE_W];
    assign sum_s       = {1'b0, cur_score_s} + (SCORE_W+1)'(roll_value);

    // Game FSM: next state, score update and turn bookkeeping.
    always_comb begin
        state_d       = state_q;
        last_result_d = last_result_q;
        player_d      = player_q;
        scores_d      = scores_q;
        turns_left_d  = turns_left_q;
        won_d         = won_q;
        draw_d        = draw_q;
        winner_d      = winner_q;
        roll_latch_s  = 1'b0;
        roll_clr_s    = 1'b0;
        won_now_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if (press_s) begin
                    scores_d      = '0;
                    player_d      = '0;
                    turns_left_d  = TURN_W'(MAX_TURNS);
                    won_d         = 1'b0;
                    draw_d        = 1'b0;
                    last_result_d = NONE;
                    roll_clr_s    = 1'b1;
                    state_d       = ROLL;
                end else begin
                    state_d = IDLE;
                end
            end
            ROLL: begin
                if (press_s) begin
                    roll_latch_s = 1'b1;
                    state_d      = CHOOSE;
                end else begin
                    state_d = ROLL;
                end
            end
            CHOOSE: begin
                if (press_s) begin
                    if (!choice) begin
                        last_result_d = SKIP;
                    end else if (sum_s == (SCORE_W+1)'(TARGET)) begin
                        last_result_d = ADD;
                        scores_d[int'(player_q)*SCORE_W +: SCORE_W] = SCORE_W'(TARGET);
                        won_d     = 1'b1;
                        winner_d  = player_q;
                        won_now_s = 1'b1;
                        state_d   = DONE;
                    end else if (sum_s < (SCORE_W+1)'(TARGET)) begin
                        last_result_d = ADD;
                        scores_d[int'(player_q)*SCORE_W +: SCORE_W] = sum_s[SCORE_W-1:0];
                    end else begin
                        last_result_d = BUST;
`ifdef DICE_BUST_RESET_EN
                        scores_d[int'(player_q)*SCORE_W +: SCORE_W] = '0;
`else
                        scores_d[int'(player_q)*SCORE_W +: SCORE_W] = cur_score_s;
`endif
                    end
                    // A full round completes when the last player hands back to player 0.
                    if (!won_now_s) begin
                        if (player_q == PID_W'(NUM_PLAYERS - 1)) begin
                            player_d = '0;
                            if (turns_left_q <= TURN_W'(1)) begin
                                turns_left_d = '0;
                                draw_d       = 1'b1;
                                state_d      = DONE;
                            end else begin
                                turns_left_d = turns_left_q - TURN_W'(1);
                                state_d      = ROLL;
                            end
                        end else begin
                            player_d = player_q + PID_W'(1);
                            state_d  = ROLL;
                        end
                    end else begin
                        player_d = player_q;
                    end
                end else begin
                    state_d = CHOOSE;
                end
            end
            DONE: begin
                if (press_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Game state registers; btn_q resets high so a held button is not a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            last_result_q <= NONE;
            player_q      <= '0;
            scores_q      <= '0;
            turns_left_q  <= TURN_W'(MAX_TURNS);
            won_q         <= 1'b0;
            draw_q        <= 1'b0;
            winner_q      <= '0;
            btn_q         <= 1'b1;
        end else begin
            state_q       <= state_d;
            last_result_q <= last_result_d;
            player_q      <= player_d;
            scores_q      <= scores_d;
            turns_left_q  <= turns_left_d;
            won_q         <= won_d;
            draw_q        <= draw_d;
            winner_q      <= winner_d;
            btn_q         <= btn;
        end
    end

    assign state       = state_q;
    assign last_result = last_result_q;
    assign player      = player_q;
    assign scores      = scores_q;
    assign turns_left  = turns_left_q;
    assign won         = won_q;
    assign draw        = draw_q;
    assign winner      = winner_q;

endmodule

// File: tb/tb_dice_game_core.sv
// Bench for dice_game_core: game-rule model compared every cycle plus directed literal checks.
module tb_dice_game_core;

    localparam int NP  = 2;
    localparam int DF  = 6;
    localparam int TGT = 15;
    localparam int MT  = 9;
    localparam int SW  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          btn = 1'b0;
    logic          choice = 1'b0;
    logic [1:0]    state;
    logic [0:0]    player;
    logic [2:0]    roll_value;
    logic [NP*SW-1:0] scores;
    logic [3:0]    turns_left;
    logic [1:0]    last_result;
    logic          won;
    logic          draw;
    logic [0:0]    winner;

    int checks = 0;
    int failures = 0;

    // model state
    int m_state, m_player, m_roll, m_turns, m_res, m_won, m_draw, m_winner;
    int m_score [NP];
    int m_ctr;
    int m_btnq;
    bit m_valid = 1'b0;

    dice_game_core #(
        .NUM_PLAYERS (NP),
        .DIE_FACES   (DF),
        .TARGET      (TGT),
        .MAX_TURNS   (MT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn         (btn),
        .choice      (choice),
        .state       (state),
        .player      (player),
        .roll_value  (roll_value),
        .scores      (scores),
        .turns_left  (turns_left),
        .last_result (last_result),
        .won         (won),
        .draw        (draw),
        .winner      (winner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Game-rule model, advanced at each active edge from the sampled inputs.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_state = 0; m_player = 0; m_roll = 0; m_turns = MT; m_res = 0;
                m_won = 0; m_draw = 0; m_winner = 0; m_ctr = 1; m_btnq = 1;
                for (int i = 0; i < NP; i++) m_score[i] = 0;
                m_valid = 1'b1;
            end else if (m_valid) begin
                bit p;
                int cap, total;
                p = btn && (m_btnq == 0);
                cap = m_ctr;
                m_ctr = (m_ctr % DF) + 1;
                m_btnq = btn ? 1 : 0;
                if (p) begin
                    case (m_state)
                        0: begin
                            for (int i = 0; i < NP; i++) m_score[i] = 0;
                            m_player = 0; m_turns = MT; m_won = 0; m_draw = 0;
                            m_res = 0; m_roll = 0; m_state = 1;
                        end
                        1: begin m_roll = cap; m_state = 2; end
                        2: begin
                            total = m_score[m_player] + m_roll;
                            if (!choice) m_res = 2;
                            else if (total == TGT) begin
                                m_res = 1; m_score[m_player] = TGT; m_won = 1;
                                m_winner = m_player; m_state = 3;
                            end else if (total < TGT) begin
                                m_res = 1; m_score[m_player] = total;
                            end else begin
                                m_res = 3;
`ifdef DICE_BUST_RESET_EN
                                m_score[m_player] = 0;
`endif
                            end
                            if (!m_won) begin
                                m_player = (m_player + 1) % NP;
                                if (m_player == 0) m_turns = m_turns - 1;
                                if (m_turns == 0) begin m_draw = 1; m_state = 3; end
                                else m_state = 1;
                            end
                        end
                        default: m_state = 0;
                    endcase
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                logic [NP*SW-1:0] es;
                for (int i = 0; i < NP; i++) es[i*SW +: SW] = SW'(m_score[i]);
                chk("state",       32'(state),       32'(m_state));
                chk("player",      32'(player),      32'(m_player));
                chk("roll_value",  32'(roll_value),  32'(m_roll));
                chk("scores",      32'(scores),      32'(es));
                chk("turns_left",  32'(turns_left),  32'(m_turns));
                chk("last_result", 32'(last_result), 32'(m_res));
                chk("won",         32'(won),         32'(m_won));
                chk("draw",        32'(draw),        32'(m_draw));
                chk("winner",      32'(winner),      32'(m_winner));
            end
        end
    end

    task automatic press();
        @(negedge clk); #1 btn = 1'b1;
        @(negedge clk); #1 btn = 1'b0;
    endtask

    task automatic press_when(input int v);
        bit found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            if (m_ctr == v) found = 1'b1;
        end
        chk("ctr_wait", 32'(found), 32'd1);
        #1 btn = 1'b1;
        @(negedge clk); #1 btn = 1'b0;
    endtask

    task automatic turn(input int v, input logic ch);
        press_when(v);
        choice = ch;
        press();
    endtask

    task automatic do_reset();
        @(negedge clk); #1 rst = 1'b1; btn = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset state
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("t1_state", 32'(state), 32'd0);
        chk("t1_scores", 32'(scores), 32'd0);
        chk("t1_turns", 32'(turns_left), 32'd9);
        chk("t1_roll", 32'(roll_value), 32'd0);
        chk("t1_won_draw", 32'({won, draw}), 32'd0);

        // 2: first kept roll of 5
        press();
        chk("t2_state_roll", 32'(state), 32'd1);
        press_when(5);
        chk("t2_roll", 32'(roll_value), 32'd5);
        choice = 1'b1;
        press();
        chk("t2_score0", 32'(scores[3:0]), 32'd5);
        chk("t2_result", 32'(last_result), 32'd1);
        chk("t2_player", 32'(player), 32'd1);
        chk("t2_state", 32'(state), 32'd1);

        // 3: exact target win from 12
        do_reset();
        press();
        turn(6, 1'b1); turn(1, 1'b0);
        turn(6, 1'b1); turn(1, 1'b0);
        chk("t3_pre", 32'(scores[3:0]), 32'd12);
        turn(3, 1'b1);
        chk("t3_score", 32'(scores[3:0]), 32'd15);
        chk("t3_won", 32'(won), 32'd1);
        chk("t3_winner", 32'(winner), 32'd0);
        chk("t3_state", 32'(state), 32'd3);
        repeat (3) @(negedge clk);
        chk("t3_hold", 32'(state), 32'd3);
        press();
        chk("t3_idle", 32'(state), 32'd0);
        chk("t3_idle_won", 32'(won), 32'd1);

        // 4: bust from 12
        do_reset();
        press();
        turn(6, 1'b1); turn(1, 1'b0);
        turn(6, 1'b1); turn(1, 1'b0);
        turn(5, 1'b1);
        chk("t4_result", 32'(last_result), 32'd3);
`ifdef DICE_BUST_RESET_EN
        chk("t4_score", 32'(scores[3:0]), 32'd0);
`else
        chk("t4_score", 32'(scores[3:0]), 32'd12);
`endif
        chk("t4_player", 32'(player), 32'd1);

        // 5: 18 skips exhaust the turn budget
        do_reset();
        press();
        for (int k = 0; k < 18; k++) begin
            turn(m_ctr, 1'b0);
            chk("t5_turns", 32'(turns_left), 32'(9 - (k + 1) / 2));
        end
        chk("t5_draw", 32'(draw), 32'd1);
        chk("t5_won", 32'(won), 32'd0);
        chk("t5_state", 32'(state), 32'd3);
        chk("t5_turns0", 32'(turns_left), 32'd0);

        // 6: reset in CHOOSE with button held through release
        do_reset();
        press();
        turn(4, 1'b1);
        press_when(2);
        chk("t6_choose", 32'(state), 32'd2);
        @(negedge clk); #1 rst = 1'b1; btn = 1'b1; choice = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_idle", 32'(state), 32'd0);
        chk("t6_scores", 32'(scores), 32'd0);
        chk("t6_roll", 32'(roll_value), 32'd0);
        #1 btn = 1'b0;
        @(negedge clk);
        chk("t6_still_idle", 32'(state), 32'd0);
        press();
        chk("t6_roll_state", 32'(state), 32'd1);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
